// File: rtl/hazard_ctrl_scb_pkg.sv
// Shared definitions for the LA32 hazard/flush controller: forwarding-source
// encodings, per-cycle cause codes and redirect FSM states.
package hazard_ctrl_scb_pkg;

  localparam int unsigned FWD_W = 3;
  localparam logic [FWD_W-1:0] FWD_NONE = '0;

  // Forward source k+1 selects the result of back-end stage k (0 = EX).
  function automatic logic [FWD_W-1:0] fwd_from_stage(input int unsigned k);
    return FWD_W'(k + 1);
  endfunction

  typedef enum logic [2:0] {
    CAUSE_EXC,
    CAUSE_HOLD,
    CAUSE_BUSY,
    CAUSE_DHAZ,
    CAUSE_MISP,
    CAUSE_BPW,
    CAUSE_RUN
  } cause_e;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } redir_state_e;

endpackage

// File: rtl/hazard_ctrl_scb_fwd_sel.sv
// Forwarding select for one ID read port against all back-end stages;
// youngest matching writer wins, and a late writer flags a data hazard.
module hazard_fwd_sel
  import hazard_ctrl_scb_pkg::*;
#(
  parameter int unsigned NSTG = 4
) (
  input  logic              rd_ren,
  input  logic [4:0]        rd_addr,
  input  logic [NSTG-1:0]   stg_wen,
  input  logic [NSTG*5-1:0] stg_waddr,
  input  logic [NSTG-1:0]   stg_late,
  output logic [FWD_W-1:0]  fwd_src,
  output logic              late
);

  logic found;

  always_comb begin
    found   = 1'b0;
    fwd_src = FWD_NONE;
    late    = 1'b0;
    if (rd_ren && (rd_addr != 5'd0)) begin
      for (int unsigned k = 0; k < NSTG; k++) begin
        if (!found && stg_wen[k] && (stg_waddr[5*k +: 5] == rd_addr)) begin
          found   = 1'b1;
          fwd_src = fwd_from_stage(k);
          late    = stg_late[k];
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_scb.sv
// Pipeline hazard/flush controller: forwarding select, stalls, kills,
// registered redirect handshake to fetch, stall watchdog and stall counter.
module hazard_ctrl_scb
  import hazard_ctrl_scb_pkg::*;
#(
  parameter int unsigned NRP    = 3,
  parameter int unsigned NSTG   = 4,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned WDOG_W = 8,
  parameter int unsigned PERF_W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NRP-1:0]       id_rd_ren,
  input  logic [NRP*5-1:0]     id_rd_addr,
  input  logic [PC_W-1:0]      id_pc,
  input  logic                 id_bp_wrong,
  input  logic [NSTG-1:0]      stg_wen,
  input  logic [NSTG*5-1:0]    stg_waddr,
  input  logic [NSTG-1:0]      stg_late,
  input  logic [NSTG-1:0]      stg_flush_req,
  input  logic [PC_W-1:0]      flush_entry,
  input  logic                 ex_busy,
  input  logic                 br_mispred,
  input  logic [PC_W-1:0]      br_target,
  input  logic                 redirect_ready,
  output logic [NRP*FWD_W-1:0] fwd_src,
  output logic                 fe_wen,
  output logic                 id_ex_wen,
  output logic                 pc_wen,
  output logic                 fe_kill,
  output logic                 id_kill,
  output logic [NSTG-1:0]      stg_kill,
  output logic                 redirect_valid,
  output logic [PC_W-1:0]      redirect_pc,
  output logic                 wdog_trip,
  output logic [PERF_W-1:0]    stall_cnt
);

  logic [NRP*FWD_W-1:0] port_src;
  logic [NRP-1:0]       port_late;
  logic [NSTG-1:0]      exc_mask;
  logic                 older_flush;
  logic                 exc_any;
  logic                 exc_wb;
  logic                 dhaz;
  cause_e               cause;
  redir_state_e         state;
  logic [PC_W-1:0]      held_pc;
  logic                 req;
  logic [PC_W-1:0]      req_pc;
  logic [WDOG_W-1:0]    wdog_cnt;
  logic [WDOG_W-1:0]    wdog_next;

  for (genvar p = 0; p < NRP; p++) begin : g_port
    hazard_fwd_sel #(
      .NSTG(NSTG)
    ) u_fwd_sel (
      .rd_ren   (id_rd_ren[p]),
      .rd_addr  (id_rd_addr[5*p +: 5]),
      .stg_wen  (stg_wen),
      .stg_waddr(stg_waddr),
      .stg_late (stg_late),
      .fwd_src  (port_src[FWD_W*p +: FWD_W]),
      .late     (port_late[p])
    );
  end

  assign exc_any = |stg_flush_req;
  assign exc_wb  = stg_flush_req[NSTG-1];
  assign dhaz    = |port_late;

  // Stage j is squashed when any older stage (higher index) holds an exception.
  always_comb begin
    exc_mask    = '0;
    older_flush = 1'b0;
    for (int unsigned i = 0; i < NSTG; i++) begin
      exc_mask[NSTG-1-i] = older_flush;
      older_flush        = older_flush | stg_flush_req[NSTG-1-i];
    end
  end

  always_comb begin
    if (exc_any)                cause = CAUSE_EXC;
    else if (state == ST_HOLD)  cause = CAUSE_HOLD;
    else if (ex_busy)           cause = CAUSE_BUSY;
    else if (dhaz)              cause = CAUSE_DHAZ;
    else if (br_mispred)        cause = CAUSE_MISP;
    else if (id_bp_wrong)       cause = CAUSE_BPW;
    else                        cause = CAUSE_RUN;
  end

  always_comb begin
    fe_wen         = 1'b1;
    id_ex_wen      = 1'b1;
    pc_wen         = 1'b1;
    fe_kill        = 1'b0;
    id_kill        = 1'b0;
    stg_kill       = '0;
    req            = 1'b0;
    req_pc         = br_target;
    unique case (cause)
      CAUSE_EXC: begin
        fe_kill  = 1'b1;
        id_kill  = 1'b1;
        stg_kill = exc_mask;
        pc_wen   = exc_wb;
        req      = exc_wb;
        req_pc   = flush_entry;
      end
      CAUSE_HOLD: begin
        pc_wen  = 1'b0;
        fe_kill = 1'b1;
      end
      CAUSE_BUSY: begin
        fe_wen      = 1'b0;
        id_ex_wen   = 1'b0;
        pc_wen      = 1'b0;
        stg_kill[0] = 1'b1;
      end
      CAUSE_DHAZ: begin
        fe_wen  = 1'b0;
        pc_wen  = 1'b0;
        id_kill = 1'b1;
      end
      CAUSE_MISP: begin
        req     = 1'b1;
        req_pc  = br_target;
        fe_kill = 1'b1;
        id_kill = 1'b1;
      end
      CAUSE_BPW: begin
        req     = 1'b1;
        req_pc  = id_pc + PC_W'(4);
        fe_kill = 1'b1;
      end
      default: ;
    endcase

    // A held redirect owns the fetch port; only a WB exception may replace it.
    if (state == ST_HOLD) begin
      redirect_valid = 1'b1;
      redirect_pc    = exc_wb ? flush_entry : held_pc;
      pc_wen         = 1'b0;
      fe_kill        = 1'b1;
    end else begin
      redirect_valid = req;
      redirect_pc    = req_pc;
    end

    if (!resetn) begin
      fe_wen         = 1'b1;
      id_ex_wen      = 1'b1;
      pc_wen         = 1'b0;
      fe_kill        = 1'b1;
      id_kill        = 1'b1;
      stg_kill       = '1;
      redirect_valid = 1'b0;
    end
  end

  assign fwd_src = resetn ? port_src : '0;

  always_comb begin
    if (fe_wen)               wdog_next = '0;
    else if (wdog_cnt == '1)  wdog_next = wdog_cnt;
    else                      wdog_next = wdog_cnt + WDOG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      held_pc   <= '0;
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
      stall_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req && !redirect_ready) begin
            state   <= ST_HOLD;
            held_pc <= req_pc;
          end
        end
        ST_HOLD: begin
          if (exc_wb)         held_pc <= flush_entry;
          if (redirect_ready) state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      wdog_cnt  <= wdog_next;
      wdog_trip <= wdog_trip | (&wdog_next);
      if (!fe_wen) stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_scb.sv
// Randomized and directed bench for hazard_ctrl_scb against a behavioural
// model of the hazard priority, redirect handshake and stall counters.
module tb_hazard_ctrl_scb;

  localparam int NRP    = 3;
  localparam int NSTG   = 4;
  localparam int PC_W   = 32;
  localparam int WDOG_W = 4;
  localparam int PERF_W = 32;
  localparam int WDOG_MAX = (1 << WDOG_W) - 1;

  logic                clk;
  logic                resetn;
  logic [NRP-1:0]      id_rd_ren;
  logic [NRP*5-1:0]    id_rd_addr;
  logic [PC_W-1:0]     id_pc;
  logic                id_bp_wrong;
  logic [NSTG-1:0]     stg_wen;
  logic [NSTG*5-1:0]   stg_waddr;
  logic [NSTG-1:0]     stg_late;
  logic [NSTG-1:0]     stg_flush_req;
  logic [PC_W-1:0]     flush_entry;
  logic                ex_busy;
  logic                br_mispred;
  logic [PC_W-1:0]     br_target;
  logic                redirect_ready;
  logic [NRP*3-1:0]    fwd_src;
  logic                fe_wen, id_ex_wen, pc_wen, fe_kill, id_kill;
  logic [NSTG-1:0]     stg_kill;
  logic                redirect_valid;
  logic [PC_W-1:0]     redirect_pc;
  logic                wdog_trip;
  logic [PERF_W-1:0]   stall_cnt;

  hazard_ctrl_scb #(
    .NRP   (NRP),
    .NSTG  (NSTG),
    .PC_W  (PC_W),
    .WDOG_W(WDOG_W),
    .PERF_W(PERF_W)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .id_rd_ren     (id_rd_ren),
    .id_rd_addr    (id_rd_addr),
    .id_pc         (id_pc),
    .id_bp_wrong   (id_bp_wrong),
    .stg_wen       (stg_wen),
    .stg_waddr     (stg_waddr),
    .stg_late      (stg_late),
    .stg_flush_req (stg_flush_req),
    .flush_entry   (flush_entry),
    .ex_busy       (ex_busy),
    .br_mispred    (br_mispred),
    .br_target     (br_target),
    .redirect_ready(redirect_ready),
    .fwd_src       (fwd_src),
    .fe_wen        (fe_wen),
    .id_ex_wen     (id_ex_wen),
    .pc_wen        (pc_wen),
    .fe_kill       (fe_kill),
    .id_kill       (id_kill),
    .stg_kill      (stg_kill),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .wdog_trip     (wdog_trip),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: pending redirect, its target, and the stall counters.
  bit               m_hold;
  logic [PC_W-1:0]  m_held;
  int               m_wdog;
  bit               m_trip;
  logic [PERF_W-1:0] m_stall;

  logic [NRP*3-1:0] e_fwd;
  logic             e_fe_wen, e_id_ex_wen, e_pc_wen, e_fe_kill, e_id_kill;
  logic [NSTG-1:0]  e_stg_kill;
  logic             e_valid;
  logic [PC_W-1:0]  e_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_eval();
    int exc_k;
    bit dh;
    bit want;
    logic [PC_W-1:0] tgt;
    logic [4:0] a;
    exc_k = -1;
    for (int k = 0; k < NSTG; k++) if (stg_flush_req[k]) exc_k = k;
    dh = 0;
    e_fwd = '0;
    for (int p = 0; p < NRP; p++) begin
      a = id_rd_addr[5*p +: 5];
      if (id_rd_ren[p] && a != 5'd0) begin
        for (int k = 0; k < NSTG; k++) begin
          if (stg_wen[k] && stg_waddr[5*k +: 5] == a) begin
            e_fwd[3*p +: 3] = 3'(k + 1);
            if (stg_late[k]) dh = 1;
            break;
          end
        end
      end
    end
    e_fe_wen = 1; e_id_ex_wen = 1; e_pc_wen = 1;
    e_fe_kill = 0; e_id_kill = 0; e_stg_kill = '0;
    want = 0; tgt = '0;
    if (exc_k >= 0) begin
      e_fe_kill = 1; e_id_kill = 1;
      for (int j = 0; j < exc_k; j++) e_stg_kill[j] = 1'b1;
      if (exc_k == NSTG - 1) begin want = 1; tgt = flush_entry; end
      else e_pc_wen = 0;
    end else if (m_hold) begin
      e_pc_wen = 0; e_fe_kill = 1;
    end else if (ex_busy) begin
      e_fe_wen = 0; e_id_ex_wen = 0; e_pc_wen = 0; e_stg_kill[0] = 1'b1;
    end else if (dh) begin
      e_fe_wen = 0; e_pc_wen = 0; e_id_kill = 1;
    end else if (br_mispred) begin
      want = 1; tgt = br_target; e_fe_kill = 1; e_id_kill = 1;
    end else if (id_bp_wrong) begin
      want = 1; tgt = id_pc + 32'd4; e_fe_kill = 1;
    end
    if (m_hold) begin
      e_valid = 1;
      e_pc = (exc_k == NSTG - 1) ? flush_entry : m_held;
      e_pc_wen = 0; e_fe_kill = 1;
    end else begin
      e_valid = want;
      e_pc = tgt;
    end
    if (!resetn) begin
      e_fe_wen = 1; e_id_ex_wen = 1; e_pc_wen = 0;
      e_fe_kill = 1; e_id_kill = 1; e_stg_kill = '1;
      e_valid = 0; e_fwd = '0;
    end
  endtask

  task automatic model_update();
    if (!resetn) begin
      m_hold = 0; m_held = '0; m_wdog = 0; m_trip = 0; m_stall = '0;
    end else begin
      if (!e_fe_wen) begin
        m_stall = m_stall + 1;
        if (m_wdog < WDOG_MAX) m_wdog++;
      end else begin
        m_wdog = 0;
      end
      if (m_wdog == WDOG_MAX) m_trip = 1;
      if (m_hold) begin
        if (stg_flush_req[NSTG-1]) m_held = flush_entry;
        if (redirect_ready) m_hold = 0;
      end else if (e_valid && !redirect_ready) begin
        m_hold = 1;
        m_held = e_pc;
      end
    end
  endtask

  // Inputs are changed 1 time unit after posedge; outputs are checked mid-cycle.
  task automatic settle_check();
    #3;
    model_eval();
    check("fwd_src",   fwd_src,   e_fwd);
    check("fe_wen",    fe_wen,    e_fe_wen);
    check("id_ex_wen", id_ex_wen, e_id_ex_wen);
    check("pc_wen",    pc_wen,    e_pc_wen);
    check("fe_kill",   fe_kill,   e_fe_kill);
    check("id_kill",   id_kill,   e_id_kill);
    check("stg_kill",  stg_kill,  e_stg_kill);
    check("redirect_valid", redirect_valid, e_valid);
    if (e_valid) check("redirect_pc", redirect_pc, e_pc);
    check("wdog_trip", wdog_trip, m_trip);
    check("stall_cnt", stall_cnt, m_stall);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic quiet_inputs();
    resetn = 1; id_rd_ren = '0; id_rd_addr = '0; id_pc = 32'h1c00_0000;
    id_bp_wrong = 0; stg_wen = '0; stg_waddr = '0; stg_late = '0;
    stg_flush_req = '0; flush_entry = 32'h1c00_8000; ex_busy = 0;
    br_mispred = 0; br_target = '0; redirect_ready = 1;
  endtask

  task automatic rand_inputs();
    resetn = ($urandom_range(0, 49) != 0);
    id_rd_ren = NRP'($urandom);
    for (int p = 0; p < NRP; p++) id_rd_addr[5*p +: 5] = 5'($urandom_range(0, 7));
    id_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
    id_bp_wrong = ($urandom_range(0, 4) == 0);
    stg_wen = NSTG'($urandom);
    for (int k = 0; k < NSTG; k++) stg_waddr[5*k +: 5] = 5'($urandom_range(0, 7));
    stg_late = NSTG'($urandom) & NSTG'($urandom);
    stg_flush_req = ($urandom_range(0, 6) == 0) ? NSTG'($urandom) : '0;
    flush_entry = $urandom;
    ex_busy = ($urandom_range(0, 4) == 0);
    br_mispred = ($urandom_range(0, 4) == 0);
    br_target = $urandom;
    redirect_ready = ($urandom_range(0, 9) < 6);
  endtask

  task automatic do_reset();
    quiet_inputs();
    resetn = 0;
    settle_check();
    advance();
    resetn = 1;
  endtask

  initial begin
    quiet_inputs();
    resetn = 0;
    m_hold = 0; m_held = '0; m_wdog = 0; m_trip = 0; m_stall = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Youngest non-late writer of r5 forwards from EX.
    quiet_inputs();
    stg_wen = 4'b1001; stg_waddr[4:0] = 5'd5; stg_waddr[19:15] = 5'd5;
    id_rd_ren = 3'b001; id_rd_addr[4:0] = 5'd5;
    settle_check();
    check("fwd_r5_ex", fwd_src[2:0], 3'd1);
    check("fwd_r5_nostall", fe_wen, 1'b1);
    advance();

    // Load-use on r7, then forward from MM1 once the result is ready.
    quiet_inputs();
    stg_wen = 4'b0001; stg_waddr[4:0] = 5'd7; stg_late = 4'b0001;
    id_rd_ren = 3'b010; id_rd_addr[9:5] = 5'd7;
    settle_check();
    check("lduse_fe_wen", fe_wen, 1'b0);
    check("lduse_id_kill", id_kill, 1'b1);
    advance();
    stg_wen = 4'b0010; stg_waddr = '0; stg_waddr[9:5] = 5'd7; stg_late = '0;
    settle_check();
    check("lduse_fwd_mm1", fwd_src[5:3], 3'd2);
    advance();

    // Exception in WB squashes all younger stages and redirects.
    quiet_inputs();
    stg_flush_req = 4'b1010; flush_entry = 32'h1c00_0100;
    settle_check();
    check("exc_stg_kill", stg_kill, 4'b0111);
    check("exc_redirect_pc", redirect_pc, 32'h1c00_0100);
    advance();

    // Mispredict refused by fetch for three cycles.
    quiet_inputs();
    br_mispred = 1; br_target = 32'h1c00_0040; redirect_ready = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) br_mispred = 0;
      if (c == 3) redirect_ready = 1;
      settle_check();
      check("hold_valid", redirect_valid, 1'b1);
      check("hold_pc", redirect_pc, 32'h1c00_0040);
      if (c > 0) check("hold_pc_wen", pc_wen, 1'b0);
      advance();
    end

    // WB exception replaces a held redirect in the same cycle.
    quiet_inputs();
    br_mispred = 1; br_target = 32'h1c00_0040; redirect_ready = 0;
    settle_check();
    advance();
    br_mispred = 0; stg_flush_req = 4'b1000; flush_entry = 32'h1c00_8000;
    settle_check();
    check("hold_exc_pc", redirect_pc, 32'h1c00_8000);
    advance();
    stg_flush_req = '0; redirect_ready = 1;
    settle_check();
    check("hold_exc_kept", redirect_pc, 32'h1c00_8000);
    advance();

    // Predicted-taken non-branch at the top of the address space wraps.
    quiet_inputs();
    id_bp_wrong = 1; id_pc = 32'hFFFF_FFFC;
    settle_check();
    check("bpw_wrap", redirect_pc, 32'h0000_0000);
    advance();

    // Watchdog and stall counter under a 20-cycle multicycle stall.
    do_reset();
    quiet_inputs();
    ex_busy = 1;
    for (int c = 1; c <= 20; c++) begin
      settle_check();
      advance();
      if (c == 14) check("wdog_pre", wdog_trip, 1'b0);
      if (c == 15) check("wdog_rise", wdog_trip, 1'b1);
    end
    check("stall_cnt_20", stall_cnt, 32'd20);
    check("wdog_sticky", wdog_trip, 1'b1);
    do_reset();
    settle_check();
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_wdog", wdog_trip, 1'b0);
    advance();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      settle_check();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
